// File: rtl/axi_trace_buffer.sv
// axi_trace_buffer: change-compressed trace buffer for a registered AXI capture vector.
//
// Stores {timestamp, capture} into a circular RAM whenever the captured vector changes
// (or on the first armed cycle, or on a trigger match). A mask/value trigger freezes the
// buffer post_count_i entries after the trigger entry. A registered read port dumps it.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   capture_i             registered AXI capture vector
//   arm_i / abort_i       clear-and-start / stop acquisition (arm wins)
//   trig_mask_i/value_i   trigger bit-enable and compare value
//   post_count_i          entries to store after the trigger entry
//   state_o               00 idle, 01 armed, 10 post, 11 done
//   wr_ptr_o, wrapped_o   next write index, buffer wrapped since arm
//   trig_index_o          index of the trigger entry
//   rd_addr_i, rd_data_o  read index, {timestamp, capture} one cycle later
module axi_trace_buffer #(
  parameter int unsigned WIDTH  = 378,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned TS_W   = 32,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WIDTH-1:0]      capture_i,
  input  logic                  arm_i,
  input  logic                  abort_i,
  input  logic [WIDTH-1:0]      trig_mask_i,
  input  logic [WIDTH-1:0]      trig_value_i,
  input  logic [ADDR_W-1:0]     post_count_i,
  output logic [1:0]            state_o,
  output logic [ADDR_W-1:0]     wr_ptr_o,
  output logic                  wrapped_o,
  output logic [ADDR_W-1:0]     trig_index_o,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [TS_W+WIDTH-1:0] rd_data_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StArmed = 2'b01,
    StPost  = 2'b10,
    StDone  = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   trig_idx_q, trig_idx_d;
  logic [ADDR_W-1:0]   post_left_q, post_left_d;
  logic                wrapped_q, wrapped_d;
  logic                first_q, first_d;
  logic [TS_W-1:0]     ts_q;
  logic [WIDTH-1:0]    prev_q;
  logic [TS_W+WIDTH-1:0] rd_q;
  logic                match;
  logic                changed;
  logic                we;

  logic [TS_W+WIDTH-1:0] mem [DEPTH];

  assign match   = ((capture_i ^ trig_value_i) & trig_mask_i) == '0;
  assign changed = (capture_i != prev_q) || first_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    trig_idx_d  = trig_idx_q;
    post_left_d = post_left_q;
    wrapped_d   = wrapped_q;
    first_d     = (state_q == StArmed) ? 1'b0 : first_q;
    we          = 1'b0;

    if (arm_i) begin
      // Arm has priority and suppresses any write in the same cycle.
      state_d     = StArmed;
      wr_ptr_d    = '0;
      trig_idx_d  = '0;
      post_left_d = '0;
      wrapped_d   = 1'b0;
      first_d     = 1'b1;
    end else if (abort_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StArmed: begin
          if (match) begin
            we          = 1'b1;
            trig_idx_d  = wr_ptr_q;
            post_left_d = post_count_i;
            state_d     = (post_count_i == '0) ? StDone : StPost;
          end else if (changed) begin
            we = 1'b1;
          end
        end
        StPost: begin
          if (changed) begin
            we          = 1'b1;
            post_left_d = post_left_q - ADDR_W'(1);
            if (post_left_q == ADDR_W'(1)) state_d = StDone;
          end
        end
        default: ;
      endcase
    end

    if (we) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (wr_ptr_q == ADDR_W'(DEPTH - 1)) wrapped_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      trig_idx_q  <= '0;
      post_left_q <= '0;
      wrapped_q   <= 1'b0;
      first_q     <= 1'b0;
      ts_q        <= '0;
      prev_q      <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_idx_q  <= trig_idx_d;
      post_left_q <= post_left_d;
      wrapped_q   <= wrapped_d;
      first_q     <= first_d;
      ts_q        <= ts_q + TS_W'(1);
      prev_q      <= capture_i;
      // Old data on a same-address write/read collision.
      rd_q        <= mem[rd_addr_i];
    end
  end

  // RAM is deliberately not reset so a dump survives rst_i.
  always_ff @(posedge clk_i) begin
    if (we) mem[wr_ptr_q] <= {ts_q, capture_i};
  end

  assign state_o      = state_q;
  assign wr_ptr_o     = wr_ptr_q;
  assign wrapped_o    = wrapped_q;
  assign trig_index_o = trig_idx_q;
  assign rd_data_o    = rd_q;

endmodule

// File: tb/tb_axi_trace_buffer.sv
module tb_axi_trace_buffer;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int A  = 3;
  localparam int TS = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  capture = '0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  trig_mask = '0;
  logic [W-1:0]  trig_value = '0;
  logic [A-1:0]  post_count = '0;
  logic [1:0]    state;
  logic [A-1:0]  wr_ptr;
  logic          wrapped;
  logic [A-1:0]  trig_index;
  logic [A-1:0]  rd_addr = '0;
  logic [TS+W-1:0] rd_data;

  int n_checks = 0;
  int n_pass   = 0;

  axi_trace_buffer #(
    .WIDTH (W),
    .DEPTH (D),
    .TS_W  (TS)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .capture_i    (capture),
    .arm_i        (arm),
    .abort_i      (abort),
    .trig_mask_i  (trig_mask),
    .trig_value_i (trig_value),
    .post_count_i (post_count),
    .state_o      (state),
    .wr_ptr_o     (wr_ptr),
    .wrapped_o    (wrapped),
    .trig_index_o (trig_index),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // States as plain ints: 0 idle, 1 armed, 2 post, 3 done.
  int            m_st;
  int            m_ptr;
  int            m_wrapped;
  int            m_tix;
  int            m_left;
  bit            m_first;
  logic [TS-1:0] m_ts;
  logic [W-1:0]  m_prev;
  logic [TS+W-1:0] m_mem [D];
  bit            m_known [D];
  logic [TS+W-1:0] m_rd;
  bit            m_rd_known;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_st = 0; m_ptr = 0; m_wrapped = 0; m_tix = 0; m_left = 0; m_first = 0;
    m_ts = '0; m_prev = '0; m_rd = '0; m_rd_known = 1;
  endtask

  // Predict the effect of the coming clock edge from the inputs currently driven.
  task automatic model_step();
    int  old_st;
    bit  hit;
    bit  do_wr;
    m_rd       = m_mem[rd_addr];
    m_rd_known = m_known[rd_addr];
    old_st = m_st;
    hit    = ((capture ^ trig_value) & trig_mask) == '0;
    do_wr  = 0;
    if (arm) begin
      m_st = 1; m_ptr = 0; m_wrapped = 0; m_tix = 0;
    end else if (abort) begin
      m_st = 0;
    end else if (old_st == 1 && hit) begin
      do_wr = 1; m_tix = m_ptr; m_left = int'(post_count);
      m_st = (m_left == 0) ? 3 : 2;
    end else if ((old_st == 1 || old_st == 2) && (capture != m_prev || m_first)) begin
      do_wr = 1;
      if (old_st == 2) begin
        m_left--;
        if (m_left == 0) m_st = 3;
      end
    end
    if (do_wr) begin
      m_mem[m_ptr]   = {m_ts, capture};
      m_known[m_ptr] = 1;
      m_ptr = (m_ptr + 1) % D;
      if (m_ptr == 0) m_wrapped = 1;
    end
    if (arm) m_first = 1;
    else if (old_st == 1) m_first = 0;
    m_prev = capture;
    m_ts   = m_ts + 1;
  endtask

  task automatic compare_model();
    chk("state", 64'(state), 64'(m_st));
    chk("wr_ptr", 64'(wr_ptr), 64'(m_ptr));
    chk("wrapped", 64'(wrapped), 64'(m_wrapped));
    chk("trig_index", 64'(trig_index), 64'(m_tix));
    if (m_rd_known) chk("rd_data", 64'(rd_data), 64'(m_rd));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic drive(input logic a, input logic b, input logic [W-1:0] c);
    arm = a; abort = b; capture = c;
    tick();
    arm = 1'b0; abort = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_state"}, 64'(state), 64'(0));
    chk({tag, "_wr_ptr"}, 64'(wr_ptr), 64'(0));
    chk({tag, "_wrapped"}, 64'(wrapped), 64'(0));
    chk({tag, "_trig_index"}, 64'(trig_index), 64'(0));
    chk({tag, "_rd_data"}, 64'(rd_data), 64'(0));
  endtask

  typedef struct {
    logic         arm;
    logic [W-1:0] cap;
    int           st;
    int           wr;
    int           tix;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [TS-1:0] ts0;
    logic [W-1:0]  rcap;
    int            masks [4];

    for (int i = 0; i < D; i++) begin
      m_known[i] = 0;
      m_mem[i]   = '0;
    end

    // Power-on reset, checked before any clock edge while rst is high.
    #1 rst = 1'b1;
    #1;
    model_reset();
    reset_checks("por");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Trigger sequence: mask 0xFF, value 0x42, post 3, trigger on 4th armed sample.
    trig_mask = 16'h00FF; trig_value = 16'h0042; post_count = 3'd3;
    tbl[0] = '{1'b1, 16'h0001, 1, 0, 0};
    tbl[1] = '{1'b0, 16'h0001, 1, 1, 0};
    tbl[2] = '{1'b0, 16'h0002, 1, 2, 0};
    tbl[3] = '{1'b0, 16'h0003, 1, 3, 0};
    tbl[4] = '{1'b0, 16'h0042, 2, 4, 3};
    tbl[5] = '{1'b0, 16'h0005, 2, 5, 3};
    tbl[6] = '{1'b0, 16'h0006, 2, 6, 3};
    tbl[7] = '{1'b0, 16'h0007, 3, 7, 3};
    tbl[8] = '{1'b0, 16'h0008, 3, 7, 3};
    tbl[9] = '{1'b0, 16'h0009, 3, 7, 3};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].arm, 1'b0, tbl[i].cap);
      chk($sformatf("trig_tbl%0d_state", i), 64'(state), 64'(tbl[i].st));
      chk($sformatf("trig_tbl%0d_wr_ptr", i), 64'(wr_ptr), 64'(tbl[i].wr));
      chk($sformatf("trig_tbl%0d_trig_index", i), 64'(trig_index), 64'(tbl[i].tix));
    end
    rd_addr = 3'd3;
    drive(1'b0, 1'b0, 16'h000A);
    rcap = rd_data[W-1:0];
    chk("trig_entry_value", 64'(rcap), 64'h42);

    // Change compression: 5 held for 10 cycles, then 6.
    trig_mask = 16'hFFFF; trig_value = 16'hFFFF;
    drive(1'b1, 1'b0, 16'h0005);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 16'h0005);
    chk("cmp_wr_ptr_hold", 64'(wr_ptr), 64'(1));
    drive(1'b0, 1'b0, 16'h0006);
    chk("cmp_wr_ptr", 64'(wr_ptr), 64'(2));
    drive(1'b0, 1'b1, 16'h0006);
    chk("cmp_abort_state", 64'(state), 64'(0));
    rd_addr = 3'd0;
    drive(1'b0, 1'b0, 16'h0006);
    rcap = rd_data[W-1:0];
    ts0  = rd_data[TS+W-1:W];
    chk("cmp_idx0_value", 64'(rcap), 64'h5);
    rd_addr = 3'd1;
    drive(1'b0, 1'b0, 16'h0006);
    rcap = rd_data[W-1:0];
    chk("cmp_idx1_value", 64'(rcap), 64'h6);
    chk("cmp_ts_delta", 64'(rd_data[TS+W-1:W] - ts0), 64'd10);

    // Wrap: 12 changing pre-trigger samples, trigger, post 2.
    trig_mask = 16'h00FF; trig_value = 16'h0042; post_count = 3'd2;
    drive(1'b1, 1'b0, 16'h0100);
    for (int k = 1; k <= 12; k++) drive(1'b0, 1'b0, 16'(16'h0100 + k));
    chk("wrap_pre_wr_ptr", 64'(wr_ptr), 64'(4));
    chk("wrap_pre_wrapped", 64'(wrapped), 64'(1));
    drive(1'b0, 1'b0, 16'h0042);
    drive(1'b0, 1'b0, 16'h0201);
    drive(1'b0, 1'b0, 16'h0202);
    chk("wrap_state", 64'(state), 64'(3));
    chk("wrap_wr_ptr", 64'(wr_ptr), 64'(7));
    chk("wrap_trig_index", 64'(trig_index), 64'(4));
    chk("wrap_wrapped", 64'(wrapped), 64'(1));
    rd_addr = 3'd7;
    drive(1'b0, 1'b0, 16'h0203);
    rcap = rd_data[W-1:0];
    chk("wrap_oldest", 64'(rcap), 64'h108);
    chk("wrap_frozen", 64'(wr_ptr), 64'(7));

    // post_count 0 with zero mask: trigger on first armed cycle.
    trig_mask = 16'h0000; post_count = 3'd0;
    drive(1'b1, 1'b0, 16'h0777);
    chk("p0_armed", 64'(state), 64'(1));
    drive(1'b0, 1'b0, 16'h0777);
    chk("p0_state", 64'(state), 64'(3));
    chk("p0_wr_ptr", 64'(wr_ptr), 64'(1));
    chk("p0_trig_index", 64'(trig_index), 64'(0));
    drive(1'b0, 1'b0, 16'h0778);
    chk("p0_frozen", 64'(wr_ptr), 64'(1));

    // arm + abort together in POST, then abort alone in ARMED.
    trig_mask = 16'h00FF; trig_value = 16'h0042; post_count = 3'd5;
    drive(1'b1, 1'b0, 16'h0011);
    drive(1'b0, 1'b0, 16'h0042);
    chk("aa_post", 64'(state), 64'(2));
    drive(1'b1, 1'b1, 16'h0043);
    chk("aa_state", 64'(state), 64'(1));
    chk("aa_wr_ptr", 64'(wr_ptr), 64'(0));
    drive(1'b0, 1'b1, 16'h0043);
    chk("ab_state", 64'(state), 64'(0));
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 16'(16'h0050 + i));
    chk("ab_no_writes", 64'(wr_ptr), 64'(0));
    chk("ab_idle", 64'(state), 64'(0));

    // Asynchronous reset in POST after a wrap; RAM survives.
    trig_mask = 16'h00FF; trig_value = 16'h0042; post_count = 3'd5;
    drive(1'b1, 1'b0, 16'h0300);
    for (int k = 1; k <= 9; k++) drive(1'b0, 1'b0, 16'(16'h0300 + k));
    drive(1'b0, 1'b0, 16'h0042);
    rd_addr = 3'd0;
    drive(1'b0, 1'b0, 16'h0310);
    chk("rst_pre_state", 64'(state), 64'(2));
    chk("rst_pre_wrapped", 64'(wrapped), 64'(1));
    #2 rst = 1'b1;
    #1;
    model_reset();
    reset_checks("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 16'h0310);
    rcap = rd_data[W-1:0];
    chk("rst_ram_kept", 64'(rcap), 64'h309);

    // Randomized traffic against the model.
    masks[0] = 16'h0000; masks[1] = 16'h000F; masks[2] = 16'h00FF; masks[3] = 16'hFFFF;
    for (int i = 0; i < 3000; i++) begin
      arm   = ($urandom_range(0, 39) == 0);
      abort = ($urandom_range(0, 59) == 0);
      if (arm) begin
        trig_mask  = 16'(masks[$urandom_range(0, 3)]);
        trig_value = 16'($urandom);
        post_count = 3'($urandom_range(0, D - 1));
      end
      if ($urandom_range(0, 2) == 0) capture = 16'($urandom);
      rd_addr = 3'($urandom_range(0, D - 1));
      tick();
      arm = 1'b0; abort = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_trace_buffer.md
# axi_trace_buffer

Change-compressed trace buffer fed by the registered 378-bit AXI capture vector. It stores a timestamped entry whenever the captured bus state changes, and keeps the entries in a circular on-chip RAM. A mask/value trigger freezes the buffer a programmable number of entries after the trigger, and a synchronous read port lets the debug host dump the contents afterwards.

## Interface
- WIDTH, 378: captured vector width
- DEPTH, 256: entries; power of two, ≥4; ADDR_W = $clog2(DEPTH)
- TS_W, 32: timestamp width
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, asynchronous and active-high
- capture_i  in  WIDTH  registered AXI capture vector
- arm_i  in  1  pulse; clear and start acquisition
- abort_i  in  1  pulse; stop acquisition
- trig_mask_i  in  WIDTH  trigger bit-enable
- trig_value_i  in  WIDTH  trigger compare value
- post_count_i  in  ADDR_W  entries to store after the trigger entry
- state_o  out  2  00 IDLE, 01 ARMED, 10 POST, 11 DONE
- wr_ptr_o  out  ADDR_W  next write index
- wrapped_o  out  1  buffer has wrapped at least once since arm
- trig_index_o  out  ADDR_W  index of the trigger entry
- rd_addr_i  in  ADDR_W  read index
- rd_data_o  out  TS_W+WIDTH  {timestamp, capture} at rd_addr_i

## Operation
- Reset values: state IDLE, wr_ptr_o 0, wrapped_o 0, trig_index_o 0, rd_data_o 0, timestamp 0, prev register 0, first flag 0. RAM contents are not reset.
- Timestamp counter:
  - Increments every cycle in every state and wraps modulo 2^TS_W.
  - Cleared only by rst_i.
- prev_q register: holds capture_i from the previous cycle, updated every cycle.
- Store condition, evaluated only in ARMED and POST: (capture_i != prev_q) OR first_q OR (ARMED and trigger match).
- Entry written: {timestamp, capture_i} at wr_ptr.
- After each write: wr_ptr increments modulo DEPTH. wrapped_o sets when wr_ptr steps from DEPTH-1 to 0 and stays set until the next arm.
- Trigger match: ((capture_i ^ trig_value_i) & trig_mask_i) == 0. An all-zero mask matches on the first ARMED cycle.
- State transitions:
  - IDLE: no writes. arm_i → ARMED.
  - ARMED: writes per the store condition. On match, the entry is written unconditionally, trig_index_o ← wr_ptr, and post_left ← post_count_i. Next state is POST, or DONE if post_count_i == 0.
  - POST: trigger is ignored. Each stored entry decrements post_left; the write that brings post_left to 0 → DONE.
  - DONE: no writes. The buffer is frozen until arm_i.
- arm_i, any state:
  - Next cycle: state ARMED, wr_ptr 0, wrapped 0, trig_index 0, first_q 1.
  - first_q clears after the first ARMED cycle.
- abort_i: → IDLE from ARMED or POST; pointers are kept. In DONE it also → IDLE.
- arm_i and abort_i in the same cycle: arm wins.
- post_count_i is sampled only at trigger. Its maximum of DEPTH-1 guarantees the trigger entry is never overwritten.
- Reading: the read port is independent of state. Reading during ARMED/POST returns RAM contents as of the previous edge; a same-address write-then-read returns the old data.

## Timing
- arm_i high at edge n: state_o = ARMED after edge n; the first entry is written at edge n+1.
- Trigger evaluated on capture_i in the cycle where state_o == ARMED: entry written at that edge; state_o = POST/DONE and trig_index_o valid after the same edge.
- DONE visible one cycle after the last post-trigger write.
- Read latency 1: rd_data_o registered from rd_addr_i at each edge.
- rst_i asserted mid-acquisition: all outputs return to reset values immediately (asynchronously); RAM contents persist.
- Oldest valid entry after DONE: index 0 if wrapped_o == 0, else wr_ptr_o.

## Test plan
- Reset, DEPTH=8: assert rst_i mid-POST → state_o 00, wr_ptr_o 0, wrapped_o 0, rd_data_o 0 without a clock edge.
- Change compression: arm; capture_i held at 5 for 10 cycles, then 6 → exactly 2 entries (value 5 at idx0, value 6 at idx1); timestamps differ by 10.
- Trigger with post_count_i=3, mask=0xFF, value=0x42: drive a unique value each cycle, 0x42 at the 4th → trig_index_o 3, DONE with wr_ptr_o 7; later changes are not written.
- Wrap, DEPTH=8: 12 changing pre-trigger samples, then trigger, post_count_i=2 → wrapped_o 1; trig_index_o 4; oldest entry at wr_ptr_o 7.
- post_count_i=0 with zero mask: arm → one entry at idx0; DONE one cycle after the first ARMED cycle.
- arm_i and abort_i in the same cycle while in POST → ARMED, wr_ptr_o 0; abort_i alone in ARMED → IDLE, and no writes while capture_i toggles.
